// File: rtl/flash_sr_target_if.sv
// flash_sr_target_if: SPI pin bundle between a flash-style initiator and
// the flash_sr_target responder.
//   spi_mosi  initiator -> target data
//   spi_clk   SPI clock, mode 0 (idles low, sampled on rise)
//   spi_cs_n  chip select, active low
//   spi_miso  target -> initiator data
// master: the initiator side; slave: the target side.
interface flash_sr_target_if;
  logic spi_mosi;
  logic spi_clk;
  logic spi_cs_n;
  logic spi_miso;

  modport master (output spi_mosi, output spi_clk, output spi_cs_n, input spi_miso);
  modport slave  (input spi_mosi, input spi_clk, input spi_cs_n, output spi_miso);
endinterface

// File: rtl/flash_sr_target.sv
// flash_sr_target: flash-like SPI target that implements the status-register
// lock protocol (WREN 0x06, volatile enable 0x50, WRSR 0x01, RDSR1 0x05,
// RDSR2 0x35). All SPI pins are oversampled on clk.
//   clk     system clock
//   rst_n   synchronous active-low reset
//   spi     SPI pins (slave modport); spi_miso is registered
//   sr1     SR1 as returned by RDSR1: {bits[7:2], wel, 0}
//   sr2     SR2 image
//   wr_stb  one-cycle pulse when a WRSR commits
//   wr_vol  qualifies wr_stb: 1 = enabled by 0x50, 0 = enabled by 0x06
module flash_sr_target #(
  parameter logic [7:0] SR1_INIT = 8'h00,
  parameter logic [7:0] SR2_INIT = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  flash_sr_target_if.slave     spi,
  output logic [7:0]           sr1,
  output logic [7:0]           sr2,
  output logic                 wr_stb,
  output logic                 wr_vol
);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WRSR, ST_READ, ST_IGNORE} state_t;

  state_t state_reg, state_next;

  // Input synchronizers, edge-detect registers and registered strobes.
  logic [1:0] mosi_sync, sclk_sync, cs_sync;
  logic       sclk_d, cs_d;
  logic       rise, fall, cs_fall, cs_rise;
  // settle fills with ones once the synchronizer pipeline holds real pin
  // values; armed is only set after CS has been seen high, so a CS that is
  // already low when reset releases does not open a frame.
  logic [2:0] settle;
  logic       armed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_sync <= 2'b00;
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      rise      <= 1'b0;
      fall      <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
      settle    <= 3'b000;
      armed     <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[0], spi.spi_mosi};
      sclk_sync <= {sclk_sync[0], spi.spi_clk};
      cs_sync   <= {cs_sync[0], spi.spi_cs_n};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
      rise      <= sclk_sync[1] & ~sclk_d;
      fall      <= ~sclk_sync[1] & sclk_d;
      cs_fall   <= armed & cs_d & ~cs_sync[1];
      cs_rise   <= ~cs_d & cs_sync[1];
      settle    <= {settle[1:0], 1'b1};
      if (settle[2] && cs_d && cs_sync[1]) armed <= 1'b1;
    end
  end

  // Frame and status state.
  logic [2:0] bit_cnt;
  logic [1:0] byte_idx;
  logic [6:0] rx_sh;
  logic [7:0] op;
  logic [5:0] byte1;
  logic [7:0] byte2;
  logic [6:0] tx_sh;
  logic [2:0] tx_cnt;
  logic       miso;
  logic [5:0] sr1_bits;
  logic [7:0] sr2_reg;
  logic       wel, vwe;

  logic [7:0] rx_byte;
  logic [7:0] sr1_read;
  logic [7:0] read_val;
  logic       exact8;
  logic       commit;

  assign rx_byte  = {rx_sh, mosi_sync[1]};
  assign sr1_read = {sr1_bits, wel, 1'b0};
  assign read_val = (op == 8'h35) ? sr2_reg : sr1_read;
  assign exact8   = (byte_idx == 2'd1) && (bit_cnt == 3'd0);
  // Whole bytes only, at least one data byte, and an enable present.
  assign commit   = (state_reg == ST_WRSR) && (op == 8'h01) && (bit_cnt == 3'd0) &&
                    (byte_idx >= 2'd2) && (wel | vwe);

  assign sr1          = sr1_read;
  assign sr2          = sr2_reg;
  assign spi.spi_miso = miso;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (cs_fall) state_next = ST_CMD;
      ST_CMD: begin
        if (rise && bit_cnt == 3'd7) begin
          case (rx_byte)
            8'h06, 8'h50, 8'h01: state_next = ST_WRSR;
            8'h05, 8'h35:        state_next = ST_READ;
            default:             state_next = ST_IGNORE;
          endcase
        end
      end
      default: ;
    endcase
    if (cs_fall) state_next = ST_CMD;
    // Deassert wins over any coincident SPI clock edge.
    if (cs_rise) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      byte_idx <= 2'd0;
      rx_sh    <= 7'd0;
      op       <= 8'h00;
      byte1    <= 6'd0;
      byte2    <= 8'h00;
      tx_sh    <= 7'd0;
      tx_cnt   <= 3'd0;
      miso     <= 1'b0;
      sr1_bits <= SR1_INIT[7:2];
      sr2_reg  <= SR2_INIT;
      wel      <= 1'b0;
      vwe      <= 1'b0;
      wr_stb   <= 1'b0;
      wr_vol   <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      if (cs_rise) begin
        miso <= 1'b0;
        if (state_reg == ST_WRSR) begin
          if (op == 8'h06 && exact8) wel <= 1'b1;
          if (op == 8'h50 && exact8) vwe <= 1'b1;
          if (op == 8'h01) begin
            if (commit) begin
              sr1_bits <= byte1;
              if (byte_idx == 2'd3) sr2_reg <= byte2;
              wr_stb <= 1'b1;
              wr_vol <= vwe;
            end
            // Any WRSR attempt consumes both enables.
            wel <= 1'b0;
            vwe <= 1'b0;
          end
        end
      end else if (cs_fall) begin
        bit_cnt  <= 3'd0;
        byte_idx <= 2'd0;
        tx_cnt   <= 3'd0;
        miso     <= 1'b0;
      end else if (state_reg != ST_IDLE) begin
        if (rise) begin
          rx_sh   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (byte_idx)
              2'd0:    op    <= rx_byte;
              2'd1:    byte1 <= rx_byte[7:2];
              2'd2:    byte2 <= rx_byte;
              default: ;
            endcase
            if (byte_idx != 2'd3) byte_idx <= byte_idx + 2'd1;
          end
        end
        if (fall) begin
          if (state_reg == ST_READ) begin
            // tx_cnt wraps every 8 bits, reloading the live status value.
            if (tx_cnt == 3'd0) begin
              tx_sh <= read_val[6:0];
              miso  <= read_val[7];
            end else begin
              tx_sh <= {tx_sh[5:0], 1'b0};
              miso  <= tx_sh[6];
            end
            tx_cnt <= tx_cnt + 3'd1;
          end else begin
            miso <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_flash_sr_target.sv
// tb_flash_sr_target: directed frames against flash_sr_target with a
// scoreboard. Stimulus pushes expected commits and expected MISO bytes;
// monitor processes pop and compare when the DUT strobes wr_stb or when the
// driver hands over a received byte.
module tb_flash_sr_target;
  localparam logic [7:0] SR1_INIT = 8'hA7;   // reads back as 0xA4
  localparam logic [7:0] SR2_INIT = 8'h5C;
  localparam int HALF = 8;                   // clk cycles per SCK phase

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] sr1, sr2;
  logic wr_stb, wr_vol;

  flash_sr_target_if spi_bus ();

  flash_sr_target #(.SR1_INIT(SR1_INIT), .SR2_INIT(SR2_INIT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .spi    (spi_bus),
    .sr1    (sr1),
    .sr2    (sr2),
    .wr_stb (wr_stb),
    .wr_vol (wr_vol)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_wr_q[$];   // {wr_vol, sr1, sr2}
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  obs_rd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Commit monitor.
  logic stb_prev = 1'b0;
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      chk("wr_stb_width", {31'd0, stb_prev}, 32'd0);
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got vol=%0b sr1=%0h sr2=%0h expected no commit", wr_vol, sr1, sr2);
      end else begin
        logic [16:0] e;
        e = exp_wr_q.pop_front();
        chk("wr_commit", {15'd0, wr_vol, sr1, sr2}, {15'd0, e});
        $display("commit vol=%0b sr1=%0h sr2=%0h", wr_vol, sr1, sr2);
      end
    end
    stb_prev = (wr_stb === 1'b1);
  end

  // MISO byte monitor.
  always @(negedge clk) begin
    if (obs_rd_q.size() > 0) begin
      logic [7:0] o;
      o = obs_rd_q.pop_front();
      if (exp_rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL miso_unexpected: got %0h expected none", o);
      end else begin
        logic [7:0] e;
        e = exp_rd_q.pop_front();
        chk("miso_byte", {24'd0, o}, {24'd0, e});
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_bus.spi_mosi = tx[31-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[30:0], spi_bus.spi_miso};
      spi_bus.spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_bus.spi_clk = 1'b0;
    end
    spi_bus.spi_mosi = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_bus.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    spi_bus.spi_cs_n = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] tx, input int n);
    logic [31:0] rx;
    cs_low();
    send_bits(tx, n, rx);
    cs_high();
    $display("frame tx=%08h bits=%0d", tx, n);
  endtask

  // Opcode plus 24 read clocks; the opcode phase must return zeros.
  task automatic read_frame(input logic [7:0] opc, input logic [7:0] e);
    logic [31:0] rx;
    exp_rd_q.push_back(8'h00);
    for (int k = 0; k < 3; k++) exp_rd_q.push_back(e);
    cs_low();
    send_bits({opc, 24'h0}, 32, rx);
    cs_high();
    for (int k = 3; k >= 0; k--) obs_rd_q.push_back(rx[k*8 +: 8]);
    $display("read op=%02h miso=%08h", opc, rx);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rx;
    rst_n = 1'b0;
    spi_bus.spi_cs_n = 1'b1;
    spi_bus.spi_clk  = 1'b0;
    spi_bus.spi_mosi = 1'b0;
    do_reset();

    // Reset state.
    chk("reset_sr1", {24'd0, sr1}, 32'hA4);
    chk("reset_sr2", {24'd0, sr2}, 32'h5C);
    chk("reset_miso", {31'd0, spi_bus.spi_miso}, 32'd0);
    chk("reset_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("reset_wr_vol", {31'd0, wr_vol}, 32'd0);

    // Volatile enable then a two-byte WRSR.
    frame(32'h5000_0000, 8);
    exp_wr_q.push_back({1'b1, 8'h28, 8'h03});
    frame(32'h0128_0300, 24);
    read_frame(8'h05, 8'h28);
    chk("s2_sr1", {24'd0, sr1}, 32'h28);
    chk("s2_sr2", {24'd0, sr2}, 32'h03);
    chk("s2_wr_vol", {31'd0, wr_vol}, 32'd1);

    // WRSR without enable: nothing changes.
    frame(32'h01FC_AA00, 24);
    chk("s3_sr1", {24'd0, sr1}, 32'h28);
    chk("s3_sr2", {24'd0, sr2}, 32'h03);

    // WREN sets wel, visible in RDSR1 bit 1, then consumed by WRSR.
    frame(32'h0600_0000, 8);
    read_frame(8'h05, 8'h2A);
    exp_wr_q.push_back({1'b0, 8'h44, 8'h03});
    frame(32'h0144_0000, 16);
    chk("s4_sr1", {24'd0, sr1}, 32'h44);
    chk("s4_wr_vol", {31'd0, wr_vol}, 32'd0);

    // Partial second byte aborts and still consumes the enable.
    frame(32'h5000_0000, 8);
    frame(32'h0128_F800, 21);
    frame(32'h0128_0000, 16);
    chk("s5_sr1", {24'd0, sr1}, 32'h44);

    // Enable frame longer than 8 bits does not enable.
    frame(32'h5000_0000, 16);
    frame(32'h0110_0000, 16);
    chk("s5b_sr1", {24'd0, sr1}, 32'h44);

    // Both enables set; vwe drives wr_vol.
    frame(32'h0600_0000, 8);
    frame(32'h5000_0000, 8);
    exp_wr_q.push_back({1'b1, 8'h10, 8'h03});
    frame(32'h0110_0000, 16);
    chk("s5c_sr1", {24'd0, sr1}, 32'h10);
    chk("s5c_wr_vol", {31'd0, wr_vol}, 32'd1);

    // RDSR2 and an unknown opcode.
    read_frame(8'h35, 8'h03);
    read_frame(8'h9F, 8'h00);
    chk("s6_sr1", {24'd0, sr1}, 32'h10);
    chk("s6_sr2", {24'd0, sr2}, 32'h03);

    // Reset in the middle of a WRSR payload discards the frame.
    frame(32'h5000_0000, 8);
    cs_low();
    send_bits(32'h0128_0000, 12, rx);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_bits(32'h8030_0000, 12, rx);
    cs_high();
    chk("s7_sr1", {24'd0, sr1}, 32'hA4);
    chk("s7_sr2", {24'd0, sr2}, 32'h5C);
    chk("s7_wr_vol", {31'd0, wr_vol}, 32'd0);
    frame(32'h5000_0000, 8);
    exp_wr_q.push_back({1'b1, 8'h28, 8'h03});
    frame(32'h0128_0300, 24);
    chk("s7b_sr1", {24'd0, sr1}, 32'h28);
    chk("s7b_sr2", {24'd0, sr2}, 32'h03);

    repeat (8) @(negedge clk);
    chk("pending_commits", exp_wr_q.size(), 32'd0);
    chk("pending_reads", exp_rd_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
